seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, handshaked successor to the team's combinational 16-bit adder/subtractor ALU.
- Registers operands and results.
- Adds logic ops, signed compare, status flags, and a multi-cycle shift-add multiplier.
- Sits between the register-file read stage and writeback. It uses valid/ready on both sides, so a downstream stall holds the result without losing it.

Parameters:
- WIDTH, 16, operand/result width in bits (≥2).
- OPW, 3, opcode width (fixed encoding below; must be 3).

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block accepts an operation this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- opcode  input  OPW  operation select.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  operation result.
- flag_c  output  1  carry / no-borrow / unsigned multiply overflow.
- flag_z  output  1  result == 0.
- flag_n  output  1  result[WIDTH-1].
- flag_v  output  1  signed overflow (ADD/SUB only).

Behaviour:
- Reset: synchronous, active-high, sampled on rising clk.
  - Outputs on reset: out_valid=0, result=0, all flags 0, state=IDLE, in_ready=0 during the reset cycle.
  - Reset mid-MUL aborts the operation; no result is emitted.
- Accept: an operation is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back single-cycle ops are allowed while the consumer drains.
- Opcodes:
  - 000 ADD: x+y; C = carry out; V = (x[msb]==y[msb]) && (r[msb]!=x[msb]).
  - 001 SUB: x+~y+1; C = carry out (1 = no borrow); V = (x[msb]!=y[msb]) && (r[msb]!=x[msb]).
  - 010 AND, 011 OR, 100 XOR: bitwise; C=V=0.
  - 101 SLT: result = 1 if signed x<y, else 0, zero-extended; C=V=0.
  - 110 MUL: unsigned, low WIDTH bits of x*y; C = 1 if the high WIDTH bits are nonzero; V=0.
  - 111 PASS: result = x; C=V=0.
  - Z and N are always derived from the final result.
- Latency:
  - Single-cycle ops: out_valid rises on the edge after accept.
  - MUL: out_valid rises exactly WIDTH+1 edges after accept (1 load + WIDTH iterations).
- FSM:
  - IDLE: accepting MUL -> MUL; other ops write the output register directly and stay in IDLE.
  - MUL: one shift-add step per cycle, counter WIDTH-1 down to 0. On the last step, write the output register -> IDLE.
  - in_ready=0 throughout MUL.
- Output hold: result and flags are stable while out_valid && !out_ready. out_valid falls after the out_ready handshake unless a new result is written the same edge (simultaneous drain+accept: new result replaces old, out_valid stays 1).
- Accumulator: 2*WIDTH bits, so the C flag for MUL is exact.
- Ignored inputs: x, y and opcode are ignored when not accepted.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD..OP_PASS.
  - FSM state encoding (IDLE, MUL).
  - flag index constants.
- Sub-module: seq_mul_unit, the shift-add multiplier datapath.
  - Ports: start, operands, done, product[2*WIDTH].
- seq_alu keeps the handshake, FSM, combinational ops and the output register.

Test Plan (all with WIDTH=16):
- ADD x=0xFFFF, y=0x0001 -> result 0x0000, C=1, Z=1, N=0, V=0; out_valid 1 cycle after accept.
- SUB x=0x8000, y=0x0001 -> result 0x7FFF, C=1, V=1, N=0. SUB x=0x0001, y=0x0002 -> result 0xFFFF, C=0, N=1.
- MUL x=3, y=5 -> result 0x000F, C=0, out_valid exactly 17 edges after accept, in_ready=0 during the run. MUL x=0x0100, y=0x0100 -> result 0x0000, C=1, Z=1.
- Backpressure: hold out_ready=0 after XOR x=0xF0F0, y=0xFFFF -> result 0x0F0F held, in_ready=0. Release -> stream of AND/OR/SLT completes one per cycle; SLT x=0xFFFF, y=0x0001 -> result 1.
- Reset asserted at cycle 5 of a MUL -> next cycle out_valid=0, result=0, flags 0. After deassert, in_ready=1 and a new ADD 2+2 -> result 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, FSM states, flag bit positions.
package alu_pkg;

    localparam int unsigned OPCODE_W = 3;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_ADD  = 3'b000;
    localparam opcode_t OP_SUB  = 3'b001;
    localparam opcode_t OP_AND  = 3'b010;
    localparam opcode_t OP_OR   = 3'b011;
    localparam opcode_t OP_XOR  = 3'b100;
    localparam opcode_t OP_SLT  = 3'b101;
    localparam opcode_t OP_MUL  = 3'b110;
    localparam opcode_t OP_PASS = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned NFLAGS = 4;

endpackage

// File: rtl/seq_mul_unit.sv
// Unsigned shift-add multiplier: one add/shift per cycle, WIDTH steps after start.
// done and product are combinational so the caller can capture the final step on the same edge.
module seq_mul_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW = 2 * WIDTH;

    logic              busy;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_next;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  addend;
    logic [WIDTH:0]    upper;

    // Low half holds the remaining multiplier bits; the carry of each add shifts into the top.
    always_comb begin
        addend   = acc[0] ? mcand : '0;
        upper    = {1'b0, acc[AW-1:WIDTH]} + {1'b0, addend};
        acc_next = {upper, acc[WIDTH-1:1]};
        done     = busy && (cnt == '0);
        product  = acc_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH - 1);
            acc   <= {WIDTH'(0), b};
            mcand <= a;
        end else if (busy) begin
            acc <= acc_next;
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered result/flags; single-cycle ops plus a multi-cycle multiply.
// The output register holds under backpressure; a drain and a new result may share an edge.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic [OPW-1:0]    opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v
);

    localparam int unsigned AW = 2 * WIDTH;

    state_t             state;
    state_t             state_next;
    opcode_t            op;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic               load;
    logic [AW-1:0]      product;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_sum;
    logic [WIDTH-1:0]   res_c;
    logic [NFLAGS-1:0]  flags_c;

    assign op = opcode_t'(opcode);

    seq_mul_unit #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (x),
        .b       (y),
        .done    (mul_done),
        .product (product)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mul_start) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake and control outputs
    always_comb begin
        in_ready  = !reset && (state == ST_IDLE) && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        mul_start = accept && (op == OP_MUL);
        load      = (accept && (op != OP_MUL)) || ((state == ST_MUL) && mul_done);
    end

    // Result and flags; while multiplying the only source is the multiplier product
    always_comb begin
        res_c   = '0;
        flags_c = '0;
        add_sum = {1'b0, x} + {1'b0, y};
        sub_sum = {1'b0, x} + {1'b0, ~y} + (WIDTH + 1)'(1);
        if (state == ST_MUL) begin
            res_c           = product[WIDTH-1:0];
            flags_c[FLAG_C] = |product[AW-1:WIDTH];
        end else begin
            case (op)
                OP_ADD: begin
                    res_c           = add_sum[WIDTH-1:0];
                    flags_c[FLAG_C] = add_sum[WIDTH];
                    flags_c[FLAG_V] = (x[WIDTH-1] == y[WIDTH-1]) && (add_sum[WIDTH-1] != x[WIDTH-1]);
                end
                OP_SUB: begin
                    res_c           = sub_sum[WIDTH-1:0];
                    flags_c[FLAG_C] = sub_sum[WIDTH];
                    flags_c[FLAG_V] = (x[WIDTH-1] != y[WIDTH-1]) && (sub_sum[WIDTH-1] != x[WIDTH-1]);
                end
                OP_AND:  res_c = x & y;
                OP_OR:   res_c = x | y;
                OP_XOR:  res_c = x ^ y;
                OP_SLT:  res_c = WIDTH'($signed(x) < $signed(y));
                OP_PASS: res_c = x;
                default: res_c = '0;
            endcase
        end
        flags_c[FLAG_Z] = (res_c == '0);
        flags_c[FLAG_N] = res_c[WIDTH-1];
    end

    // Output register: load wins over drain so a simultaneous drain+accept keeps out_valid high
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            result    <= res_c;
            flag_c    <= flags_c[FLAG_C];
            flag_z    <= flags_c[FLAG_Z];
            flag_n    <= flags_c[FLAG_N];
            flag_v    <= flags_c[FLAG_V];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16): hand-computed vectors covering flags, multiply
// latency, backpressure hold, streaming, and reset during a multiply.
module tb_seq_alu;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic [2:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_c;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;

    int vectors = 0;
    int errors  = 0;

    seq_alu #(
        .WIDTH (16),
        .OPW   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flags packed as {C,Z,N,V}
    function automatic logic [3:0] flags();
        return {flag_c, flag_z, flag_n, flag_v};
    endfunction

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        opcode   = op;
        x        = a;
        y        = b;
        @(negedge clk);
        check("in_ready_at_issue", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = 16'($urandom);
        y        = 16'($urandom);
        opcode   = 3'($urandom);
    endtask

    task automatic check_out(input string tag, input logic [15:0] er, input logic [3:0] ef);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_flags"}, 32'(flags()), 32'(ef));
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  s_op  [5] = '{3'b010, 3'b011, 3'b101, 3'b101, 3'b111};
    logic [15:0] s_x   [5] = '{16'h00FF, 16'h1200, 16'hFFFF, 16'h0001, 16'h8001};
    logic [15:0] s_y   [5] = '{16'h0FF0, 16'h0034, 16'h0001, 16'hFFFF, 16'h0000};
    logic [15:0] s_res [5] = '{16'h00F0, 16'h1234, 16'h0001, 16'h0000, 16'h8001};
    logic [3:0]  s_flg [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0010};

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        opcode    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags()), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue(3'b000, 16'hFFFF, 16'h0001);
        check_out("add_wrap", 16'h0000, 4'b1100);
        @(negedge clk);
        check("add_drained", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        issue(3'b001, 16'h8000, 16'h0001);
        check_out("sub_ovf", 16'h7FFF, 4'b1001);
        issue(3'b001, 16'h0001, 16'h0002);
        check_out("sub_borrow", 16'hFFFF, 4'b0010);

        // Multiply latency: count edges from the accepting edge to out_valid
        issue(3'b110, 16'd3, 16'd5);
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            check("mul_in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("mul_latency", 32'(n), 32'd17);
        check("mul_result", 32'(result), 32'h000F);
        check("mul_flags", 32'(flags()), 32'b0000);
        @(posedge clk);
        #1;

        issue(3'b110, 16'h0100, 16'h0100);
        repeat (16) @(posedge clk);
        #1;
        check_out("mul_ovf", 16'h0000, 4'b1100);

        // Backpressure: result held, a pending op must not be taken
        out_ready = 1'b0;
        issue(3'b100, 16'hF0F0, 16'hFFFF);
        in_valid = 1'b1;
        opcode   = s_op[0];
        x        = s_x[0];
        y        = s_y[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(result), 32'h0F0F);
            check("hold_flags", 32'(flags()), 32'b0000);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;

        // Release: one op accepted per cycle while the previous result drains
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_result", 32'(result), 32'(s_res[i-1]));
                check("stream_flags", 32'(flags()), 32'(s_flg[i-1]));
            end
            @(posedge clk);
            #1;
            if (i < 4) begin
                opcode = s_op[i+1];
                x      = s_x[i+1];
                y      = s_y[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("stream_last_result", 32'(result), 32'(s_res[4]));
        check("stream_last_flags", 32'(flags()), 32'(s_flg[4]));
        @(posedge clk);
        #1;

        // Reset during a multiply aborts it
        issue(3'b110, 16'd7, 16'd9);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'(flags()), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("abort_no_result", 32'(out_valid), 32'd0);
        check("abort_ready_again", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        issue(3'b000, 16'd2, 16'd2);
        check_out("add_after_reset", 16'h0004, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
